cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_seq_pkg.sv | 45 ++++
 rtl/seq_wait_timer.sv | 30 +++
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction-phase sequencer.
// STEPWAIT exists only when CPU_SEQ_SINGLE_STEP_EN is defined.
package cpu_seq_pkg;

    localparam int unsigned WAIT_TIMEOUT_DEF = 15;
    localparam int unsigned WAIT_CNT_W       = 8;
    localparam int unsigned RETIRED_W        = 8;
    localparam int unsigned PHASE_W          = 4;

    // Phase strobes packed as {fetch, decode, execute, writeback}
    localparam logic [PHASE_W-1:0] PH_NONE      = 4'b0000;
    localparam logic [PHASE_W-1:0] PH_FETCH     = 4'b1000;
    localparam logic [PHASE_W-1:0] PH_DECODE    = 4'b0100;
    localparam logic [PHASE_W-1:0] PH_EXECUTE   = 4'b0010;
    localparam logic [PHASE_W-1:0] PH_WRITEBACK = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_FAULT     = 3'd6
`ifdef CPU_SEQ_SINGLE_STEP_EN
        ,
        S_STEPWAIT  = 3'd7
`endif
    } seq_state_e;

    // One-hot phase strobe pattern for a given state
    function automatic logic [PHASE_W-1:0] phase_of(input seq_state_e s);
        logic [PHASE_W-1:0] ph;
        ph = PH_NONE;
        case (s)
            S_FETCH:     ph = PH_FETCH;
            S_DECODE:    ph = PH_DECODE;
            S_EXECUTE:   ph = PH_EXECUTE;
            S_WRITEBACK: ph = PH_WRITEBACK;
            default:     ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive FETCH stall cycles; flags the stall that would reach the limit.
module seq_wait_timer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic timeout_c
);

    logic [WAIT_CNT_W-1:0] cnt_q;

    // Current cycle is the WAIT_TIMEOUT-th consecutive stall
    assign timeout_c = count && (cnt_q == WAIT_CNT_W'(WAIT_TIMEOUT - 1));

    // Stall counter; clear wins over count, holds once the limit is hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && !timeout_c) begin
            cnt_q <= cnt_q + WAIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Four-phase instruction sequencer (fetch/decode/execute/writeback) with
// halt, stall timeout fault and retired-instruction counter.
// Optional single-step mode: define CPU_SEQ_SINGLE_STEP_EN.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mem_wait,
    input  logic                 halt_req,
    input  logic                 resume,
    input  logic                 step_mode,
    input  logic                 step,
    output logic                 fetch,
    output logic                 decode,
    output logic                 execute,
    output logic                 writeback,
    output logic                 pc_inc,
    output logic                 halted,
    output logic                 fault,
    output logic [RETIRED_W-1:0] retired
);

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic                 retire_c;
    logic                 timer_clear_c;
    logic                 timer_count_c;
    logic                 timeout_c;

    logic [PHASE_W-1:0]   phase_q;
    logic                 pc_inc_q;
    logic                 halted_q;
    logic                 fault_q;
    logic [RETIRED_W-1:0] retired_q;

`ifndef CPU_SEQ_SINGLE_STEP_EN
    // Step controls have no effect without single-step support
    logic unused_step;
    assign unused_step = ^{step_mode, step};
`endif

    // Stall counter restarts on every entry into FETCH
    assign timer_clear_c = (state_d == S_FETCH) && (state_q != S_FETCH);
    assign timer_count_c = (state_q == S_FETCH) && mem_wait;

    seq_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk       (clock),
        .rst_n     (reset),
        .clear     (timer_clear_c),
        .count     (timer_count_c),
        .timeout_c (timeout_c)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!mem_wait)      state_d = S_DECODE;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = halt_req ? S_HALTED : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                retire_c = 1'b1;
                if (!enable) begin
                    state_d = S_IDLE;
`ifdef CPU_SEQ_SINGLE_STEP_EN
                end else if (step_mode) begin
                    state_d = S_STEPWAIT;
`endif
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                if (resume) state_d = enable ? S_FETCH : S_IDLE;
            end
`ifdef CPU_SEQ_SINGLE_STEP_EN
            S_STEPWAIT: begin
                if (!enable)                state_d = S_IDLE;
                else if (step || !step_mode) state_d = S_FETCH;
            end
`endif
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output registers track the state being entered, so strobes align with state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q   <= PH_NONE;
            pc_inc_q  <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            phase_q  <= phase_of(state_d);
            pc_inc_q <= (state_d == S_WRITEBACK);
            halted_q <= (state_d == S_HALTED);
            fault_q  <= (state_d == S_FAULT);
            if (retire_c) begin
                retired_q <= retired_q + RETIRED_W'(1);
            end
        end
    end

    assign fetch     = phase_q[3];
    assign decode    = phase_q[2];
    assign execute   = phase_q[1];
    assign writeback = phase_q[0];
    assign pc_inc    = pc_inc_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (WAIT_TIMEOUT = 15).
module tb_cpu_sequencer;

    localparam logic [3:0] PF = 4'b1000;
    localparam logic [3:0] PD = 4'b0100;
    localparam logic [3:0] PE = 4'b0010;
    localparam logic [3:0] PW = 4'b0001;
    localparam logic [3:0] PN = 4'b0000;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       mem_wait;
    logic       halt_req;
    logic       resume;
    logic       step_mode;
    logic       step;
    logic       fetch;
    logic       decode;
    logic       execute;
    logic       writeback;
    logic       pc_inc;
    logic       halted;
    logic       fault;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    cpu_sequencer #(
        .WAIT_TIMEOUT (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mem_wait  (mem_wait),
        .halt_req  (halt_req),
        .resume    (resume),
        .step_mode (step_mode),
        .step      (step),
        .fetch     (fetch),
        .decode    (decode),
        .execute   (execute),
        .writeback (writeback),
        .pc_inc    (pc_inc),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr();
        repeat (4) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares {fetch,decode,execute,writeback,pc_inc,halted,fault}
    task automatic st(input string tag, input logic [3:0] ph, input logic pc, input logic hl,
                      input logic ft);
        chk(tag, 16'({fetch, decode, execute, writeback, pc_inc, halted, fault}),
            16'({ph, pc, hl, ft}));
    endtask

    task automatic ret(input string tag, input logic [7:0] exp);
        chk(tag, 16'(retired), 16'(exp));
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        mem_wait  = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;

        // Reset state
        repeat (2) tick();
        st("reset_outputs", PN, 1'b0, 1'b0, 1'b0);
        ret("reset_retired", 8'd0);

        reset = 1'b1;
        tick();
        st("idle_no_enable", PN, 1'b0, 1'b0, 1'b0);

        // Two back-to-back instructions, no stalls
        enable = 1'b1;
        tick(); st("i1_fetch",     PF, 1'b0, 1'b0, 1'b0);
        tick(); st("i1_decode",    PD, 1'b0, 1'b0, 1'b0);
        tick(); st("i1_execute",   PE, 1'b0, 1'b0, 1'b0);
        tick(); st("i1_writeback", PW, 1'b1, 1'b0, 1'b0);
        ret("i1_retired_in_wb", 8'd0);
        tick(); st("i2_fetch",     PF, 1'b0, 1'b0, 1'b0);
        ret("i1_retired", 8'd1);
        tick(); st("i2_decode",    PD, 1'b0, 1'b0, 1'b0);
        tick(); st("i2_execute",   PE, 1'b0, 1'b0, 1'b0);
        tick(); st("i2_writeback", PW, 1'b1, 1'b0, 1'b0);
        tick(); st("i3_fetch",     PF, 1'b0, 1'b0, 1'b0);
        ret("i2_retired", 8'd2);

        // Three stall cycles hold FETCH for four cycles
        mem_wait = 1'b1;
        tick(); st("stall_f2", PF, 1'b0, 1'b0, 1'b0);
        tick(); st("stall_f3", PF, 1'b0, 1'b0, 1'b0);
        tick(); st("stall_f4", PF, 1'b0, 1'b0, 1'b0);
        mem_wait = 1'b0;
        tick(); st("stall_decode", PD, 1'b0, 1'b0, 1'b0);
        tick(); st("i3_execute",   PE, 1'b0, 1'b0, 1'b0);

        // Halt skips writeback; resume restarts fetch
        halt_req = 1'b1;
        tick(); st("halted", PN, 1'b0, 1'b1, 1'b0);
        ret("halt_retired", 8'd2);
        tick(); st("halted_hold", PN, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0;
        resume   = 1'b1;
        tick(); st("resume_fetch", PF, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;

        // Enable dropped in DECODE completes the instruction then idles
        tick(); st("drop_decode", PD, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        tick(); st("drop_execute",   PE, 1'b0, 1'b0, 1'b0);
        tick(); st("drop_writeback", PW, 1'b1, 1'b0, 1'b0);
        tick(); st("drop_idle",      PN, 1'b0, 1'b0, 1'b0);
        ret("drop_retired", 8'd3);
        tick(); st("drop_idle_hold", PN, 1'b0, 1'b0, 1'b0);

        // Retired counter wraps 255 -> 0
        enable = 1'b1;
        tick();
        repeat (252) run_instr();
        st("pre_wrap_fetch", PF, 1'b0, 1'b0, 1'b0);
        ret("pre_wrap", 8'd255);
        run_instr();
        ret("wrap", 8'd0);

        // Single-step behaviour
        step_mode = 1'b1;
        tick(); st("sm_decode",    PD, 1'b0, 1'b0, 1'b0);
        tick(); st("sm_execute",   PE, 1'b0, 1'b0, 1'b0);
        tick(); st("sm_writeback", PW, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef CPU_SEQ_SINGLE_STEP_EN
        st("stepwait", PN, 1'b0, 1'b0, 1'b0);
        ret("stepwait_retired", 8'd1);
        tick(); st("stepwait_hold", PN, 1'b0, 1'b0, 1'b0);
        step = 1'b1;
        tick(); st("step_fetch", PF, 1'b0, 1'b0, 1'b0);
        step = 1'b0;
        tick(); st("step_decode",    PD, 1'b0, 1'b0, 1'b0);
        tick(); st("step_execute",   PE, 1'b0, 1'b0, 1'b0);
        tick(); st("step_writeback", PW, 1'b1, 1'b0, 1'b0);
        tick(); st("step_wait2",     PN, 1'b0, 1'b0, 1'b0);
        ret("step_retired", 8'd2);
        enable = 1'b0;
        step   = 1'b1;
        tick(); st("step_disable_idle", PN, 1'b0, 1'b0, 1'b0);
        step   = 1'b0;
        enable = 1'b1;
        tick(); st("idle_to_fetch", PF, 1'b0, 1'b0, 1'b0);
        step_mode = 1'b0;
`else
        st("no_step_fetch", PF, 1'b0, 1'b0, 1'b0);
        ret("no_step_retired", 8'd1);
        step_mode = 1'b0;
`endif

        // Asynchronous reset mid-instruction abandons it
        tick(); st("pre_rst_decode",  PD, 1'b0, 1'b0, 1'b0);
        tick(); st("pre_rst_execute", PE, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        st("async_reset", PN, 1'b0, 1'b0, 1'b0);
        ret("async_reset_retired", 8'd0);
        tick();
        reset = 1'b1;
        tick(); st("post_rst_fetch", PF, 1'b0, 1'b0, 1'b0);
        ret("post_rst_retired", 8'd0);

        // Continuous stall: 15 stall cycles then sticky FAULT
        mem_wait = 1'b1;
        repeat (14) tick();
        st("stall_15th", PF, 1'b0, 1'b0, 1'b0);
        tick(); st("fault_entry", PN, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            enable   = i[0];
            mem_wait = i[1];
            resume   = i[0];
            halt_req = ~i[0];
            tick(); st("fault_sticky", PN, 1'b0, 1'b0, 1'b1);
        end
        resume   = 1'b0;
        halt_req = 1'b0;
        mem_wait = 1'b0;
        reset    = 1'b0;
        #1;
        st("fault_cleared", PN, 1'b0, 1'b0, 1'b0);

        // Resume with enable low returns to IDLE
        enable = 1'b1;
        tick();
        reset = 1'b1;
        tick(); st("h2_fetch",   PF, 1'b0, 1'b0, 1'b0);
        tick(); st("h2_decode",  PD, 1'b0, 1'b0, 1'b0);
        tick(); st("h2_execute", PE, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b1;
        tick(); st("h2_halted", PN, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0;
        enable   = 1'b0;
        resume   = 1'b1;
        tick(); st("h2_resume_idle", PN, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;
        tick(); st("h2_idle_hold", PN, 1'b0, 1'b0, 1'b0);
        ret("h2_retired", 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
